// File: rtl/repetition_matcher.sv
// repetition_matcher: turns the a/b event streams into registered match pulses
// for consecutive-a and a->goto-b repetitions. It also flags a/b spacing
// violations and keeps saturating hit counters for readout.
//
// Goto FSM states
//   state  | meaning
//   IDLE   | no a seen yet, or the last goto sequence has completed
//   WAIT_B | a seen; counting b samples towards GOTO_COUNT
module repetition_matcher #(
  parameter int CONSEC_LEN = 5,
  parameter int GOTO_COUNT = 2,
  parameter int MIN_GAP    = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a,
  input  logic             b,
  input  logic             clr,
  output logic             consec_match,
  output logic             goto_match,
  output logic             goto_busy,
  output logic [CNT_W-1:0] consec_hits,
  output logic [CNT_W-1:0] goto_hits,
  output logic             err_gap,
  output logic             err_bb
);

  localparam int RUN_W  = $clog2(CONSEC_LEN + 1);
  localparam int BCNT_W = $clog2(GOTO_COUNT + 1);
  localparam int GAP_W  = $clog2(MIN_GAP + 1);

  localparam logic [RUN_W-1:0]  RUN_LAST  = RUN_W'(CONSEC_LEN - 1);
  localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(GOTO_COUNT - 1);
  localparam logic [GAP_W-1:0]  GAP_LOAD  = GAP_W'(MIN_GAP - 1);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] WAIT_B = 1'b1;

  logic [0:0]        state;
  logic [RUN_W-1:0]  run;
  logic [BCNT_W-1:0] bcnt;
  logic [GAP_W-1:0]  gap;
  logic              b_prev;

  logic consec_hit;
  logic goto_hit;
  logic gap_viol;
  logic bb_viol;

  // Decode this edge's trigger and violation conditions
  always_comb begin
    consec_hit = a && (run == RUN_LAST);
    goto_hit   = (state == WAIT_B) && !a && b && (bcnt == BCNT_LAST);
    gap_viol   = b && (a || (gap != '0));
    bb_viol    = b && b_prev;
  end

  assign goto_busy = (state == WAIT_B);

  // Consecutive-a run counter; restarts after every match so matches never overlap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run          <= '0;
      consec_match <= 1'b0;
    end else begin
      consec_match <= consec_hit;
      if (!a || consec_hit)
        run <= '0;
      else
        run <= run + 1'b1;
    end
  end

  // Goto FSM: an a (re)arms the sequence; a b in the same cycle as an a is ignored
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      bcnt       <= '0;
      goto_match <= 1'b0;
    end else begin
      goto_match <= goto_hit;
      case (state)
        IDLE: begin
          if (a) begin
            state <= WAIT_B;
            bcnt  <= '0;
          end
        end
        WAIT_B: begin
          if (a) begin
            bcnt <= '0;
          end else if (b) begin
            if (goto_hit) begin
              state <= IDLE;
              bcnt  <= '0;
            end else begin
              bcnt <= bcnt + 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          bcnt  <= '0;
        end
      endcase
    end
  end

  // Gap window counter and previous-b history for the spacing checks
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gap    <= '0;
      b_prev <= 1'b0;
    end else begin
      b_prev <= b;
      if (a)
        gap <= GAP_LOAD;
      else if (gap != '0)
        gap <= gap - 1'b1;
    end
  end

  // Sticky error flags; a violation in the clear cycle keeps its flag set
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_gap <= 1'b0;
      err_bb  <= 1'b0;
    end else if (clr) begin
      err_gap <= gap_viol;
      err_bb  <= bb_viol;
    end else begin
      err_gap <= err_gap | gap_viol;
      err_bb  <= err_bb | bb_viol;
    end
  end

  // Saturating hit counters, updated on the same edge that registers the pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      consec_hits <= '0;
      goto_hits   <= '0;
    end else if (clr) begin
      consec_hits <= {{(CNT_W-1){1'b0}}, consec_hit};
      goto_hits   <= {{(CNT_W-1){1'b0}}, goto_hit};
    end else begin
      if (consec_hit && (consec_hits != '1))
        consec_hits <= consec_hits + 1'b1;
      if (goto_hit && (goto_hits != '1))
        goto_hits <= goto_hits + 1'b1;
    end
  end

endmodule
